completion_scheduler: RTL and testbench

- In-order completion scheduler for the renamed register file.
- Tracks up to DEPTH dispatched instructions (2 per cycle, slot A older than slot B) in a circular buffer.
- Collects out-of-order finish reports from execution and retires the oldest finished instructions in program order, at most 2 per cycle.
- Drives the register file's update enable/address pair that commits RRF values to the ARF.

---
 rtl/completion_scheduler_if.sv | 47 ++++
 rtl/completion_scheduler.sv | 133 +++++++++++++
 tb/tb_completion_scheduler.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/completion_scheduler_if.sv
// Dispatch, finish and commit signals of the completion scheduler.
// The scheduler uses the slave modport; the pipeline driving it uses master.
interface completion_scheduler_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3,
    parameter int unsigned REG_W = 5
);
    logic              flush;
    logic              alloc_en_A;
    logic              alloc_en_B;
    logic              alloc_wr_A;
    logic              alloc_wr_B;
    logic [REG_W-1:0]  alloc_rd_A;
    logic [REG_W-1:0]  alloc_rd_B;
    logic              alloc_ready;
    logic [PTR_W-1:0]  alloc_tag_A;
    logic [PTR_W-1:0]  alloc_tag_B;
    logic              fin_en_A;
    logic [PTR_W-1:0]  fin_tag_A;
    logic              fin_en_B;
    logic [PTR_W-1:0]  fin_tag_B;
    logic              update_en_A;
    logic [REG_W-1:0]  update_addr_A;
    logic              update_en_B;
    logic [REG_W-1:0]  update_addr_B;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;

    modport slave (
        input  flush,
        input  alloc_en_A, alloc_en_B, alloc_wr_A, alloc_wr_B, alloc_rd_A, alloc_rd_B,
        output alloc_ready, alloc_tag_A, alloc_tag_B,
        input  fin_en_A, fin_tag_A, fin_en_B, fin_tag_B,
        output update_en_A, update_addr_A, update_en_B, update_addr_B,
        output count, empty, full
    );

    modport master (
        output flush,
        output alloc_en_A, alloc_en_B, alloc_wr_A, alloc_wr_B, alloc_rd_A, alloc_rd_B,
        input  alloc_ready, alloc_tag_A, alloc_tag_B,
        output fin_en_A, fin_tag_A, fin_en_B, fin_tag_B,
        input  update_en_A, update_addr_A, update_en_B, update_addr_B,
        input  count, empty, full
    );
endinterface

// File: rtl/completion_scheduler.sv
// In-order completion scheduler: circular buffer of in-flight instructions,
// out-of-order finish marking, in-order retirement of up to two per cycle and
// registered commit (update) signals towards the architectural register file.
module completion_scheduler #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3,
    parameter int unsigned REG_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    completion_scheduler_if.slave   bus
);
    localparam int unsigned CntW = PTR_W + 1;

    // Buffer state
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CntW-1:0]  r_count;
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;
    logic [DEPTH-1:0] r_wr;
    logic [REG_W-1:0] r_rd [DEPTH];

    // Registered commit outputs
    logic             r_upd_en_a;
    logic             r_upd_en_b;
    logic [REG_W-1:0] r_upd_addr_a;
    logic [REG_W-1:0] r_upd_addr_b;

    logic             w_clear;
    logic             w_ready;
    logic             w_acc_a;
    logic             w_acc_b;
    logic [PTR_W-1:0] w_tag_a;
    logic [PTR_W-1:0] w_tag_b;
    logic [PTR_W-1:0] w_head1;
    logic             w_ret_a;
    logic             w_ret_b;
    logic             w_same_rd;
    logic             w_commit_a;
    logic             w_commit_b;
    logic [CntW-1:0]  w_n_alloc;
    logic [CntW-1:0]  w_n_ret;

    // Allocation acceptance, tag assignment and retire decision
    always_comb begin
        w_clear    = !rst_n || bus.flush;
        // Space check uses the pre-retire count; same-cycle retires do not help
        w_ready    = (r_count <= CntW'(DEPTH - 2));
        w_acc_a    = bus.alloc_en_A & w_ready;
        w_acc_b    = bus.alloc_en_B & w_ready;
        w_tag_a    = r_tail;
        w_tag_b    = bus.alloc_en_A ? r_tail + PTR_W'(1) : r_tail;
        w_head1    = r_head + PTR_W'(1);
        w_ret_a    = r_valid[r_head] & r_done[r_head];
        // Two writers to the same register must commit in separate cycles
        w_same_rd  = r_wr[r_head] & r_wr[w_head1] & (r_rd[r_head] == r_rd[w_head1]);
        w_ret_b    = w_ret_a & r_valid[w_head1] & r_done[w_head1] & ~w_same_rd;
        w_commit_a = w_ret_a & r_wr[r_head];
        w_commit_b = w_ret_b & r_wr[w_head1];
        w_n_alloc  = CntW'(w_acc_a) + CntW'(w_acc_b);
        w_n_ret    = CntW'(w_ret_a) + CntW'(w_ret_b);
    end

    // Pointer, count and per-entry state update
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            // Finish marks only live entries; a late report for a freed tag is dropped
            if (bus.fin_en_A && r_valid[bus.fin_tag_A]) begin
                r_done[bus.fin_tag_A] <= 1'b1;
            end
            if (bus.fin_en_B && r_valid[bus.fin_tag_B]) begin
                r_done[bus.fin_tag_B] <= 1'b1;
            end
            if (w_ret_a) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
            end
            if (w_ret_b) begin
                r_valid[w_head1] <= 1'b0;
                r_done[w_head1]  <= 1'b0;
            end
            // Allocated slots are free, so they never collide with retiring ones
            if (w_acc_a) begin
                r_valid[w_tag_a] <= 1'b1;
                r_done[w_tag_a]  <= 1'b0;
                r_wr[w_tag_a]    <= bus.alloc_wr_A;
                r_rd[w_tag_a]    <= bus.alloc_rd_A;
            end
            if (w_acc_b) begin
                r_valid[w_tag_b] <= 1'b1;
                r_done[w_tag_b]  <= 1'b0;
                r_wr[w_tag_b]    <= bus.alloc_wr_B;
                r_rd[w_tag_b]    <= bus.alloc_rd_B;
            end
            r_head  <= r_head + PTR_W'(w_n_ret);
            r_tail  <= r_tail + PTR_W'(w_n_alloc);
            r_count <= r_count + w_n_alloc - w_n_ret;
        end
    end

    // Commit outputs, one cycle after the retire decision
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_upd_en_a   <= 1'b0;
            r_upd_en_b   <= 1'b0;
            r_upd_addr_a <= '0;
            r_upd_addr_b <= '0;
        end else begin
            r_upd_en_a   <= w_commit_a;
            r_upd_en_b   <= w_commit_b;
            r_upd_addr_a <= w_commit_a ? r_rd[r_head] : '0;
            r_upd_addr_b <= w_commit_b ? r_rd[w_head1] : '0;
        end
    end

    assign bus.alloc_ready   = w_ready;
    assign bus.alloc_tag_A   = w_tag_a;
    assign bus.alloc_tag_B   = w_tag_b;
    assign bus.update_en_A   = r_upd_en_a;
    assign bus.update_addr_A = r_upd_addr_a;
    assign bus.update_en_B   = r_upd_en_b;
    assign bus.update_addr_B = r_upd_addr_b;
    assign bus.count         = r_count;
    assign bus.empty         = (r_count == '0);
    assign bus.full          = (r_count == CntW'(DEPTH));
endmodule

// File: tb/tb_completion_scheduler.sv
// Bench for completion_scheduler: queue-based reference model, commit scoreboard
// checked by an independent monitor, directed scenarios then random traffic.
module tb_completion_scheduler;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;
    localparam int REG_W = 5;

    logic clk = 1'b0;
    logic rst_n;

    completion_scheduler_if #(.DEPTH(DEPTH), .PTR_W(PTR_W), .REG_W(REG_W)) bus ();

    completion_scheduler #(.DEPTH(DEPTH), .PTR_W(PTR_W), .REG_W(REG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered list of in-flight instructions
    typedef struct {
        int tag;
        bit wr;
        int rd;
        bit done;
    } ent_t;

    // Expected commit event for one cycle
    typedef struct {
        int cyc;
        bit en_a;
        int addr_a;
        bit en_b;
        int addr_b;
    } rec_t;

    ent_t mq[$];
    rec_t sb[$];
    int   m_tail;
    int   cyc;
    int   n_pass;
    int   n_total;
    bit   mon_en;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic idle();
        bus.flush      = 1'b0;
        bus.alloc_en_A = 1'b0;
        bus.alloc_en_B = 1'b0;
        bus.alloc_wr_A = 1'b0;
        bus.alloc_wr_B = 1'b0;
        bus.alloc_rd_A = '0;
        bus.alloc_rd_B = '0;
        bus.fin_en_A   = 1'b0;
        bus.fin_tag_A  = '0;
        bus.fin_en_B   = 1'b0;
        bus.fin_tag_B  = '0;
    endtask

    task automatic set_alloc(input bit ea, input bit wa, input int ra,
                             input bit eb, input bit wb, input int rb);
        bus.alloc_en_A = ea;
        bus.alloc_wr_A = wa;
        bus.alloc_rd_A = REG_W'(ra);
        bus.alloc_en_B = eb;
        bus.alloc_wr_B = wb;
        bus.alloc_rd_B = REG_W'(rb);
    endtask

    task automatic set_fin(input bit ea, input int ta, input bit eb, input int tb);
        bus.fin_en_A  = ea;
        bus.fin_tag_A = PTR_W'(ta);
        bus.fin_en_B  = eb;
        bus.fin_tag_B = PTR_W'(tb);
    endtask

    // Check combinational outputs, advance the model by one cycle, then clock
    task automatic step();
        int   nret;
        bit   ready;
        rec_t r;
        ent_t e;
        #3;
        ready = (DEPTH - mq.size()) >= 2;
        check("count", int'(bus.count), mq.size());
        check("empty", int'(bus.empty), int'(mq.size() == 0));
        check("full", int'(bus.full), int'(mq.size() == DEPTH));
        check("alloc_ready", int'(bus.alloc_ready), int'(ready));
        check("alloc_tag_A", int'(bus.alloc_tag_A), m_tail);
        check("alloc_tag_B", int'(bus.alloc_tag_B),
              bus.alloc_en_A ? (m_tail + 1) % DEPTH : m_tail);
        if (!rst_n || bus.flush) begin
            mq.delete();
            m_tail = 0;
        end else begin
            nret = 0;
            if (mq.size() >= 1 && mq[0].done) begin
                nret = 1;
                if (mq.size() >= 2 && mq[1].done &&
                    !(mq[0].wr && mq[1].wr && mq[0].rd == mq[1].rd)) nret = 2;
            end
            foreach (mq[i]) begin
                if ((bus.fin_en_A && mq[i].tag == int'(bus.fin_tag_A)) ||
                    (bus.fin_en_B && mq[i].tag == int'(bus.fin_tag_B))) mq[i].done = 1'b1;
            end
            r.cyc    = cyc + 1;
            r.en_a   = (nret >= 1) && mq[0].wr;
            r.addr_a = r.en_a ? mq[0].rd : 0;
            r.en_b   = (nret >= 2) && mq[1].wr;
            r.addr_b = r.en_b ? mq[1].rd : 0;
            if (r.en_a || r.en_b) sb.push_back(r);
            repeat (nret) void'(mq.pop_front());
            if (ready) begin
                if (bus.alloc_en_A) begin
                    e = '{tag: m_tail, wr: bus.alloc_wr_A, rd: int'(bus.alloc_rd_A), done: 1'b0};
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % DEPTH;
                end
                if (bus.alloc_en_B) begin
                    e = '{tag: m_tail, wr: bus.alloc_wr_B, rd: int'(bus.alloc_rd_B), done: 1'b0};
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Commit monitor: every asserted update must match the next scoreboard entry
    always @(negedge clk) begin
        rec_t r;
        if (mon_en) begin
            if (bus.update_en_A || bus.update_en_B) begin
                if (sb.size() == 0) begin
                    check("unexpected_update", 1, 0);
                end else begin
                    r = sb.pop_front();
                    check("update_cycle", cyc, r.cyc);
                    check("update_en_A", int'(bus.update_en_A), int'(r.en_a));
                    check("update_addr_A", int'(bus.update_addr_A), r.addr_a);
                    check("update_en_B", int'(bus.update_en_B), int'(r.en_b));
                    check("update_addr_B", int'(bus.update_addr_B), r.addr_b);
                end
            end else begin
                check("idle_addr_A", int'(bus.update_addr_A), 0);
                check("idle_addr_B", int'(bus.update_addr_B), 0);
            end
        end
    end

    initial begin
        int ta;
        int tb;
        cyc    = 0;
        n_pass = 0;
        n_total = 0;
        mon_en = 1'b0;
        m_tail = 0;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset();

        // Pair commits together once the older one finishes
        set_alloc(1, 1, 3, 1, 1, 4); step();
        idle(); step();
        set_fin(1, 1, 0, 0); step();
        idle(); step(); step();
        set_fin(1, 0, 0, 0); step();
        idle(); repeat (3) step();

        // Fill to full, rejected fifth pair, then free space
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_alloc(1, 1, 10 + 2 * i, 1, 1, 11 + 2 * i); step();
        end
        idle();
        set_fin(1, 0, 1, 1); step();
        idle(); repeat (3) step();
        for (int t = 2; t < 8; t += 2) begin
            set_fin(1, t, 1, t + 1); step();
        end
        idle(); repeat (4) step();

        // Same destination pair splits across two cycles
        do_reset();
        set_alloc(1, 1, 7, 1, 1, 7); step();
        idle(); set_fin(1, 0, 1, 1); step();
        idle(); repeat (4) step();

        // Non-writer at head, writer behind it
        do_reset();
        set_alloc(1, 0, 0, 1, 1, 9); step();
        idle(); set_fin(1, 1, 1, 0); step();
        idle(); repeat (3) step();

        // Single allocations with immediate finishes across the tag wrap
        do_reset();
        for (int i = 0; i < 21; i++) begin
            idle();
            if (i < 20) set_alloc(1, 1, i, 0, 0, 0);
            if (i > 0) set_fin(1, (i - 1) % DEPTH, 0, 0);
            step();
        end
        idle(); repeat (3) step();

        // Flush with five in flight, alongside alloc and finish
        do_reset();
        set_alloc(1, 1, 1, 1, 1, 2); step();
        set_alloc(1, 1, 5, 1, 1, 6); step();
        set_alloc(1, 1, 8, 0, 0, 0); step();
        idle(); set_fin(1, 0, 1, 1); step();
        set_alloc(1, 1, 12, 0, 0, 0); set_fin(1, 2, 0, 0); bus.flush = 1'b1; step();
        idle(); repeat (4) step();

        // Random traffic with occasional flush and reset
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst_n = ($urandom_range(0, 299) != 0);
            bus.flush = ($urandom_range(0, 99) == 0);
            set_alloc($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 7),
                      $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 7));
            ta = (mq.size() > 0 && $urandom_range(0, 3) != 0)
                 ? mq[$urandom_range(0, mq.size() - 1)].tag : $urandom_range(0, DEPTH - 1);
            tb = (mq.size() > 0 && $urandom_range(0, 3) != 0)
                 ? mq[$urandom_range(0, mq.size() - 1)].tag : $urandom_range(0, DEPTH - 1);
            set_fin($urandom_range(0, 1), ta, $urandom_range(0, 1), tb);
            step();
        end

        // Drain everything still in flight
        idle();
        rst_n = 1'b1;
        for (int n = 0; n < 40 && mq.size() > 0; n++) begin
            idle();
            set_fin(1, mq[0].tag, mq.size() > 1, mq.size() > 1 ? mq[1].tag : 0);
            step();
        end
        idle(); repeat (3) step();
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
